// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS32 control unit: opcodes, FSM states,
// mux selects and the per-state Moore control word.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPE_EX = 4'd7,
        RTYPE_WB = 4'd8,
        BRANCH   = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11,
        JUMP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    // Pure state-decoded controls; the mem_ready-qualified strobes are added in the top.
    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = ALUB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_b = ALUB_IMMSH;
                c.alu_op    = ALUOP_ADD;
            end
            MEMADR, ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            RTYPE_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            RTYPE_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = ALUB_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            ADDI_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_JUMP;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcu_wait_timer.sv
// Saturating memory-wait counter; expired flags the last permitted wait cycle.
module mcu_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT > 0) && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS32 control FSM with a ready/timeout handshake to shared memory.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int TIMEOUT = 16,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               instr_done,
    output logic               illegal_op,
    output logic               mem_timeout,
    output logic [STATE_W-1:0] state
);

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl_q;
    logic   branch_ne_q;

    logic waiting, expired, timeout_hit, fetch_ready;
    logic is_lw, is_sw, is_rtype, is_beq, is_bne, is_addi, is_j, is_known;

    assign is_lw    = (opcode == OPC_W'(OP_LW));
    assign is_sw    = (opcode == OPC_W'(OP_SW));
    assign is_rtype = (opcode == OPC_W'(OP_RTYPE));
    assign is_beq   = (opcode == OPC_W'(OP_BEQ));
    assign is_bne   = (opcode == OPC_W'(OP_BNE));
    assign is_addi  = (opcode == OPC_W'(OP_ADDI));
    assign is_j     = (opcode == OPC_W'(OP_J));
    assign is_known = is_lw | is_sw | is_rtype | is_beq | is_bne | is_addi | is_j;

    assign waiting     = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    assign timeout_hit = waiting && !mem_ready && expired;
    assign fetch_ready = (cur == FETCH) && mem_ready;

    // NOTE: nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:     nxt = FETCH;
            FETCH:    nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (is_lw || is_sw)          nxt = MEMADR;
                else if (is_rtype)           nxt = RTYPE_EX;
                else if (is_beq || is_bne)   nxt = BRANCH;
                else if (is_addi)            nxt = ADDI_EX;
                else if (is_j)               nxt = JUMP;
                else                         nxt = FETCH;
            end
            MEMADR:   nxt = is_lw ? MEMRD : MEMWR;
            MEMRD:    nxt = mem_ready ? MEMWB : (timeout_hit ? FETCH : MEMRD);
            MEMWR:    nxt = (mem_ready || timeout_hit) ? FETCH : MEMWR;
            RTYPE_EX: nxt = RTYPE_WB;
            ADDI_EX:  nxt = ADDI_WB;
            MEMWB, RTYPE_WB, BRANCH, ADDI_WB, JUMP: nxt = FETCH;
            default:  nxt = IDLE;
        endcase
    end

    // Moore controls are registered from the next state so they line up with cur.
    // NOTE: output flops reset with the state register, so every output drops the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= IDLE;
            ctrl_q      <= '0;
            branch_ne_q <= 1'b0;
        end else begin
            cur         <= nxt;
            ctrl_q      <= moore_ctrl(nxt);
            branch_ne_q <= (nxt == BRANCH) && is_bne;
        end
    end

    mcu_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_en (waiting && !mem_ready),
        .clear    ((nxt != cur) || mem_ready || timeout_hit),
        .expired  (expired)
    );

    assign pc_write      = ctrl_q.pc_write | fetch_ready;
    assign ir_write      = fetch_ready;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign branch_ne     = branch_ne_q;
    assign pc_source     = ctrl_q.pc_source;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign instr_done    = ctrl_q.instr_done | ((cur == MEMWR) && mem_ready);
    assign illegal_op    = (cur == DECODE) && !is_known;
    assign mem_timeout   = timeout_hit;
    assign state         = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized instruction stream checked cycle by cycle against a per-instruction trace model.
module tb_multicycle_control_unit;
    import mcu_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = '0;

    logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op, mem_timeout;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OPC_W(6), .TIMEOUT(TIMEOUT), .STATE_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout),
        .state         (state)
    );

    wire [19:0] obs = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
                       mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                       alu_src_b, alu_op, instr_done, illegal_op, mem_timeout};

    function automatic bit legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    endfunction

    // Expected control outputs for one cycle, straight from the per-state output table.
    function automatic logic [19:0] exp_out(input state_t s, input logic [5:0] op,
                                            input bit rdy, input bit tmo);
        logic pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, done, ill, to;
        logic [1:0] psrc, asb, aop;
        {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, done, ill, to} = '0;
        {psrc, asb, aop} = '0;
        case (s)
            FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; to = tmo; end
            DECODE:   begin asb = 2'b11; ill = !legal(op); end
            MEMADR:   begin asa = 1; asb = 2'b10; end
            MEMRD:    begin mr = 1; iod = 1; to = tmo; end
            MEMWB:    begin rw = 1; m2r = 1; done = 1; end
            MEMWR:    begin mw = 1; iod = 1; done = rdy; to = tmo; end
            RTYPE_EX: begin asa = 1; aop = 2'b10; end
            RTYPE_WB: begin rw = 1; rd = 1; done = 1; end
            BRANCH:   begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1;
                            bne = (op == 6'h05); end
            ADDI_EX:  begin asa = 1; asb = 2'b10; end
            ADDI_WB:  begin rw = 1; done = 1; end
            JUMP:     begin pw = 1; psrc = 2'b10; done = 1; end
            default:  ;
        endcase
        return {pw, pwc, bne, psrc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, done, ill, to};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1; drives inputs, then samples on the falling edge.
    task automatic step(input state_t s, input logic [5:0] op, input bit rdy, input bit tmo);
        mem_ready = rdy;
        opcode    = op;
        @(negedge clk);
        check($sformatf("state@%0d", cyc), 32'(state), 32'(s));
        check($sformatf("ctrl@%0d", cyc), 32'(obs), 32'(exp_out(s, op, rdy, tmo)));
        check($sformatf("rd_wr_excl@%0d", cyc), 32'(mem_read & mem_write), 32'd0);
        check($sformatf("rw_wr_excl@%0d", cyc), 32'(reg_write & mem_write), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // A memory phase with `waits` not-ready cycles before ready; the 16th
    // consecutive not-ready cycle aborts (FETCH retries in place).
    task automatic wait_phase(input state_t s, input logic [5:0] op, input int waits,
                              output bit aborted);
        int k = 0;
        int left = waits;
        aborted = 1'b0;
        while (1) begin
            if (left == 0) begin
                step(s, op, 1'b1, 1'b0);
                return;
            end
            if (k == TIMEOUT - 1) begin
                step(s, op, 1'b0, 1'b1);
                left--;
                if (s != FETCH) begin
                    aborted = 1'b1;
                    return;
                end
                k = 0;
            end else begin
                step(s, op, 1'b0, 1'b0);
                left--;
                k++;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        bit ab;
        wait_phase(FETCH, op, fw, ab);
        step(DECODE, op, 1'($urandom_range(0, 1)), 1'b0);
        case (op)
            OP_LW: begin
                step(MEMADR, op, 1'($urandom_range(0, 1)), 1'b0);
                wait_phase(MEMRD, op, mw, ab);
                if (!ab) step(MEMWB, op, 1'($urandom_range(0, 1)), 1'b0);
            end
            OP_SW: begin
                step(MEMADR, op, 1'($urandom_range(0, 1)), 1'b0);
                wait_phase(MEMWR, op, mw, ab);
            end
            OP_RTYPE: begin
                step(RTYPE_EX, op, 1'($urandom_range(0, 1)), 1'b0);
                step(RTYPE_WB, op, 1'($urandom_range(0, 1)), 1'b0);
            end
            OP_BEQ, OP_BNE: step(BRANCH, op, 1'($urandom_range(0, 1)), 1'b0);
            OP_ADDI: begin
                step(ADDI_EX, op, 1'($urandom_range(0, 1)), 1'b0);
                step(ADDI_WB, op, 1'($urandom_range(0, 1)), 1'b0);
            end
            OP_J: step(JUMP, op, 1'($urandom_range(0, 1)), 1'b0);
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        bit ab;
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctrl", 32'(obs), 32'd0);
        rst_n = 1'b1;
        step(IDLE, 6'h00, 1'b1, 1'b0);

        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_SW, 0, 16);
        run_instr(OP_SW, 0, 15);
        run_instr(6'h3F, 0, 0);
        run_instr(OP_ADDI, 2, 0);
        run_instr(OP_J, 20, 0);
        run_instr(OP_LW, 0, 20);
        run_instr(OP_LW, 15, 15);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            int fw, mw;
            if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 6)];
            else                          op = 6'($urandom);
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            mw = $urandom_range(0, 20);
            run_instr(op, fw, mw);
        end

        // Asynchronous reset while a load is waiting on memory.
        wait_phase(FETCH, OP_LW, 0, ab);
        step(DECODE, OP_LW, 1'b0, 1'b0);
        step(MEMADR, OP_LW, 1'b0, 1'b0);
        step(MEMRD, OP_LW, 1'b0, 1'b0);
        step(MEMRD, OP_LW, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_ctrl", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        check("arst_hold_state", 32'(state), 32'd0);
        check("arst_hold_ctrl", 32'(obs), 32'd0);
        rst_n = 1'b1;
        step(IDLE, 6'h00, 1'b1, 1'b0);
        run_instr(OP_RTYPE, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

endmodule
